rtdc_set_ctrl: RTL

Time-set and sequencing controller for the BCD real-time clock counter chain and its seven-segment decode.
- Generates the 1 Hz advance enable (tick_en).
- Runs a two-button set-mode state machine for editing hours and minutes.
- Issues a single-cycle parallel load to the counters.
- Produces a per-digit blank mask so the digit under edit blinks.

---
 rtl/rtdc_pkg.sv | 25 ++
 rtl/rtdc_bcd_wrap_inc.sv | 27 ++
 rtl/rtdc_set_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/rtdc_pkg.sv
// rtdc_pkg: shared types and constants for the real-time-clock set controller.
//   state_t  - controller states; the encoding is also exported on the mode port
//   bcd2_t   - two-digit packed BCD value {tens, units}
//   HR_MAX   - last valid hours value before wrapping to 00
//   MIN_MAX  - last valid minutes value before wrapping to 00
//   BLANK_*  - digit blank masks {hr_m,hr_l,min_m,min_l,sec_m,sec_l}
package rtdc_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  typedef logic [7:0] bcd2_t;

  localparam bcd2_t HR_MAX  = 8'h23;
  localparam bcd2_t MIN_MAX = 8'h59;

  localparam logic [5:0] BLANK_NONE = 6'b000000;
  localparam logic [5:0] BLANK_HR   = 6'b110000;
  localparam logic [5:0] BLANK_MIN  = 6'b001100;

endpackage

// File: rtl/rtdc_bcd_wrap_inc.sv
// rtdc_bcd_wrap_inc: combinational two-digit BCD increment that wraps to 00
// after MAX.
//   Parameters: MAX - last value before the wrap (BCD, e.g. 8'h23 or 8'h59)
//   Ports:      val - current BCD value
//               inc - val + 1 in BCD, or 00 when val has reached MAX
module rtdc_bcd_wrap_inc
  import rtdc_pkg::*;
#(
  parameter bcd2_t MAX = MIN_MAX
) (
  input  logic [7:0] val,
  output logic [7:0] inc
);

  // Valid BCD orders the same way as binary, so ">=" also folds any
  // out-of-range value from the counter chain back to 00.
  always_comb begin
    if (val >= MAX) begin
      inc = 8'h00;
    end else if (val[3:0] >= 4'd9) begin
      inc = {val[7:4] + 4'd1, 4'd0};
    end else begin
      inc = {val[7:4], val[3:0] + 4'd1};
    end
  end

endmodule

// File: rtl/rtdc_set_ctrl.sv
// rtdc_set_ctrl: time-set and sequencing controller for the BCD RTC chain.
//   Generates the 1 Hz advance pulse, runs the two-button hours/minutes set
//   state machine, issues a one-cycle parallel load and blinks the digit
//   pair under edit. All state updates on the falling edge of clk.
//
//   Parameters: TICK_DIV  - clk cycles per tick_en pulse (>= 2)
//               BLINK_DIV - clk cycles per blink phase (>= 1)
//               TIMEOUT_S - idle seconds before set mode aborts
//   Optional:   define RTDC_SET_TIMEOUT_EN to build the set-mode timeout.
//
//   Ports: clk, rst (async, active high)
//          btn_mode, btn_inc   - debounced single-cycle button pulses
//          cur_hr, cur_min     - current BCD time from the counter chain
//          tick_en             - one-cycle advance to the seconds counter
//          load, ld_hr, ld_min - parallel load strobe and BCD load values
//          blank               - per-digit blank mask, 1 = dark
//          mode                - state encoding for status LEDs
module rtdc_set_ctrl
  import rtdc_pkg::*;
#(
  parameter int TICK_DIV  = 50000000,
  parameter int BLINK_DIV = 25000000,
  parameter int TIMEOUT_S = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [7:0] cur_hr,
  input  logic [7:0] cur_min,
  output logic       tick_en,
  output logic       load,
  output logic [7:0] ld_hr,
  output logic [7:0] ld_min,
  output logic [5:0] blank,
  output logic [1:0] mode
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  state_t        state, state_nx;
  bcd2_t         edit_hr, edit_min;
  bcd2_t         hr_inc, min_inc;
  logic [PW-1:0] presc;
  logic [BW-1:0] blink_cnt;
  logic          blink_ph;

  logic in_set;
  logic inc_ok;
  logic state_chg;
  logic presc_last;
  logic presc_en;
  logic presc_clr;
  logic timeout;

  assign in_set     = (state == SET_HR) || (state == SET_MIN);
  // btn_mode wins over a simultaneous btn_inc.
  assign inc_ok     = btn_inc && !btn_mode && in_set;
  assign state_chg  = (state_nx != state);
  assign presc_last = (presc == PRESC_LAST);

  rtdc_bcd_wrap_inc #(.MAX(HR_MAX)) u_hr_inc (
    .val (edit_hr),
    .inc (hr_inc)
  );

  rtdc_bcd_wrap_inc #(.MAX(MIN_MAX)) u_min_inc (
    .val (edit_min),
    .inc (min_inc)
  );

`ifdef RTDC_SET_TIMEOUT_EN
  // The prescaler also runs in the set states so it can time the idle
  // seconds; tick_en stays gated to RUN so the clock itself does not advance.
  localparam int SW = $clog2(TIMEOUT_S + 1);
  localparam logic [SW-1:0] SEC_LAST = SW'(TIMEOUT_S - 1);

  logic [SW-1:0] sec_cnt;
  logic          btn_any;

  assign btn_any   = btn_mode || btn_inc;
  assign presc_en  = (state == RUN) || in_set;
  assign presc_clr = in_set && btn_any;
  assign timeout   = in_set && !btn_any && presc_last && (sec_cnt == SEC_LAST);

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      sec_cnt <= '0;
    end else if (!in_set || btn_any || state_chg) begin
      sec_cnt <= '0;
    end else if (presc_last) begin
      sec_cnt <= sec_cnt + 1'b1;
    end
  end
`else
  assign presc_en  = (state == RUN);
  assign presc_clr = 1'b0;
  // Constant false; TIMEOUT_S only matters when the timeout is built.
  assign timeout   = (TIMEOUT_S < 0);
`endif

  // NOTE: every output of a combinational block is given a default first so
  // no path through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      RUN:     if (btn_mode) state_nx = SET_HR;
      SET_HR:  if (btn_mode) state_nx = SET_MIN;
               else if (timeout) state_nx = RUN;
      SET_MIN: if (btn_mode) state_nx = COMMIT;
               else if (timeout) state_nx = RUN;
      COMMIT:  state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values; the asynchronous reset sits in the sensitivity list.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nx;
    end
  end

  // Edit registers: snapshot the live time on entry, bump the selected field
  // on accepted increments, and drop everything on a timeout abort.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      edit_hr  <= 8'h00;
      edit_min <= 8'h00;
    end else if (state == RUN && btn_mode) begin
      edit_hr  <= cur_hr;
      edit_min <= cur_min;
    end else if (timeout) begin
      edit_hr  <= 8'h00;
      edit_min <= 8'h00;
    end else if (inc_ok && state == SET_HR) begin
      edit_hr  <= hr_inc;
    end else if (inc_ok && state == SET_MIN) begin
      edit_min <= min_inc;
    end
  end

  // Clearing on every state change makes the first tick after COMMIT land a
  // full TICK_DIV cycles after re-entering RUN.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (!presc_en || state_chg || presc_clr || presc_last) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Blink restarts on every state change and accepted increment so the digits
  // stay solid while they are being stepped.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (!in_set || state_chg || inc_ok) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_ph  <= ~blink_ph;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_comb begin
    blank = BLANK_NONE;
    if (blink_ph) begin
      if (state == SET_HR)  blank = BLANK_HR;
      if (state == SET_MIN) blank = BLANK_MIN;
    end
  end

  assign tick_en = (state == RUN) && presc_last;
  assign load    = (state == COMMIT);
  assign ld_hr   = edit_hr;
  assign ld_min  = edit_min;
  assign mode    = state;

endmodule
